gpu_cmd_sched: RTL

Command scheduler between the CPU core and the rasterizer. CPU-side drawing commands (fill, point, line, rect) are buffered in a small FIFO and issued to the rasterizer one at a time over a request/busy handshake, so the CPU never stalls on a long raster operation unless the queue is full. It sits in the top level between the control logic's GPU write path and the rasterizer port.

---
 rtl/gpu_cmd_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_sched.sv
// gpu_cmd_sched: buffers CPU drawing commands in a small FIFO and issues them
// to the rasterizer one at a time over an execute-request / busy handshake.
// Optional feature macro: GPU_SCHED_CLIP_EN -- when defined, coordinates are
// clamped to the 214x160 framebuffer (x <= 213, y <= 159) as they enter the queue.
module gpu_cmd_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_async,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_x0,
  input  logic [7:0]               cmd_y0,
  input  logic [7:0]               cmd_x1,
  input  logic [7:0]               cmd_y1,
  input  logic [2:0]               cmd_colour,
  input  logic                     flush,
  output logic [1:0]               rast_command,
  output logic [7:0]               rast_x0,
  output logic [7:0]               rast_y0,
  output logic [7:0]               rast_x1,
  output logic [7:0]               rast_y1,
  output logic [2:0]               rast_colour,
  output logic                     rast_execute_request,
  input  logic                     rast_busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     sched_idle
);

  localparam int AW      = $clog2(DEPTH);
  // One entry: {op, x0, y0, x1, y1, colour}
  localparam int ENTRY_W = 2 + 4 * 8 + 3;
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  // Number of WAIT_ACK cycles tolerated without busy, minus one
  localparam logic [1:0]  ACK_LIMIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [1:0]           ack_cnt;
  logic [ENTRY_W-1:0]   out_q;
  logic                 req_q;
  logic [ENTRY_W-1:0]   entry_in;
  logic                 push;
  logic                 pop;

`ifdef GPU_SCHED_CLIP_EN
  localparam logic [7:0] X_MAX = 8'd213;
  localparam logic [7:0] Y_MAX = 8'd159;

  // Saturate a coordinate to the last visible pixel of its axis
  function automatic logic [7:0] clamp_coord(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign entry_in = {cmd_op,
                     clamp_coord(cmd_x0, X_MAX), clamp_coord(cmd_y0, Y_MAX),
                     clamp_coord(cmd_x1, X_MAX), clamp_coord(cmd_y1, Y_MAX),
                     cmd_colour};
`else
  assign entry_in = {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour};
`endif

  // Occupancy and CPU-side flow control come straight from the registered pointers,
  // so a pop while full only frees a slot from the following cycle on.
  assign queue_count = wptr - rptr;
  assign cmd_ready   = (queue_count < DEPTH_C);
  assign sched_idle  = (state == IDLE) && (queue_count == '0);

  // A command arriving together with flush is discarded along with the queue
  assign push = cmd_valid && cmd_ready && !flush;

  // Next-state logic; pop happens only from IDLE and never in a flush cycle
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if ((queue_count != '0) && !rast_busy && !flush) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (rast_busy) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == ACK_LIMIT) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!rast_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts cycles spent in WAIT_ACK for the no-acknowledge timeout
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      ack_cnt <= 2'd0;
    end else if (state == WAIT_ACK) begin
      ack_cnt <= ack_cnt + 2'd1;
    end else begin
      ack_cnt <= 2'd0;
    end
  end

  // Queue pointers; flush drops everything still queued but not the in-flight command
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Queue storage is data only and needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= entry_in;
    end
  end

  // Output register and issue strobe; data holds from ISSUE until the next pop
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      out_q <= '0;
      req_q <= 1'b0;
    end else begin
      req_q <= pop;
      if (pop) begin
        out_q <= mem[rptr[AW-1:0]];
      end
    end
  end

  assign {rast_command, rast_x0, rast_y0, rast_x1, rast_y1, rast_colour} = out_q;
  assign rast_execute_request = req_q;

endmodule
